// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: sequencer state encoding and counter sizing helper.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Step counter width: $clog2 of the step count, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_serial_subtractor_digit_sub.sv
// Combinational DIGIT-bit ripple-borrow cell: {b_o, d} = a_d - b_d - b_i.
module digit_sub #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             b_i,
    output logic [DIGIT-1:0] d,
    output logic             b_o
);

    logic brw;

    always_comb begin
        d   = '0;
        brw = b_i;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            d[i] = a_d[i] ^ b_d[i] ^ brw;
            brw  = (~a_d[i] & b_d[i]) | (~(a_d[i] ^ b_d[i]) & brw);
        end
        b_o = brw;
    end

endmodule

// File: rtl/digit_serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - borrow_in, DIGIT bits per clock, LSD first,
// with a start/busy/done handshake and registered results.
module digit_serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] r_sr_q, r_sr_d;
    logic             brw_q, brw_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             zero_q, zero_d;

    logic [DIGIT-1:0]       cell_d;
    logic                   cell_bo;
    logic [WIDTH+DIGIT-1:0] r_cat;
    logic [WIDTH-1:0]       r_next;

    digit_sub #(
        .DIGIT(DIGIT)
    ) u_cell (
        .a_d(a_sr_q[DIGIT-1:0]),
        .b_d(b_sr_q[DIGIT-1:0]),
        .b_i(brw_q),
        .d  (cell_d),
        .b_o(cell_bo)
    );

    // New digit enters at the MSB end; the concatenation also covers DIGIT == WIDTH.
    assign r_cat  = {cell_d, r_sr_q};
    assign r_next = r_cat[WIDTH+DIGIT-1:DIGIT];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        r_sr_d       = r_sr_q;
        brw_d        = brw_q;
        busy_d       = busy_q;
        done_d       = done_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        zero_d       = zero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                done_d  = 1'b0;
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    brw_d   = borrow_in;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                a_sr_d = a_sr_q >> DIGIT;
                b_sr_d = b_sr_q >> DIGIT;
                r_sr_d = r_next;
                brw_d  = cell_bo;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d      = ST_DONE;
                    cnt_d        = '0;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    diff_d       = r_next;
                    borrow_out_d = cell_bo;
                    zero_d       = (r_next == '0);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            r_sr_q       <= '0;
            brw_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            r_sr_q       <= r_sr_d;
            brw_q        <= brw_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            zero_q       <= zero_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Bench for digit_serial_subtractor: DIGIT=1 and DIGIT=4 instances, cycle model plus literal checks.
module tb_digit_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       s1 = 1'b0, c1 = 1'b0, s4 = 1'b0, c4 = 1'b0;
    logic [7:0] a1 = '0, b1 = '0, a4 = '0, b4 = '0;
    logic       busy1, done1, bo1, z1, busy4, done4, bo4, z4;
    logic [7:0] diff1, diff4;

    int checks = 0;
    int errors = 0;

    digit_serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .borrow_in(c1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1), .zero(z1)
    );

    digit_serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4), .borrow_in(c4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4), .zero(z4)
    );

    typedef struct {
        int         rem;
        bit         busy;
        bit         done;
        logic [7:0] diff;
        bit         bo;
        bit         z;
        logic [7:0] pa;
        logic [7:0] pb;
        bit         pc;
    } mdl_t;

    function automatic mdl_t mreset();
        mdl_t m;
        m.rem = 0; m.busy = 0; m.done = 0; m.diff = '0; m.bo = 0; m.z = 0;
        m.pa = '0; m.pb = '0; m.pc = 0;
        return m;
    endfunction

    // One clock of the handshake: operation takes n edges, result computed with plain integer subtraction.
    function automatic mdl_t mstep(mdl_t m, bit s, logic [7:0] a, logic [7:0] b, bit c, int n);
        int full;
        if (m.rem > 0) begin
            m.rem--;
            if (m.rem == 0) begin
                full   = int'(m.pa) - int'(m.pb) - int'(m.pc);
                m.diff = full[7:0];
                m.bo   = (full < 0);
                m.z    = (m.diff == 8'h00);
                m.busy = 0;
                m.done = 1;
            end
        end else begin
            m.done = 0;
            if (s) begin
                m.busy = 1;
                m.rem  = n;
                m.pa   = a;
                m.pb   = b;
                m.pc   = c;
            end
        end
        return m;
    endfunction

    mdl_t m1 = mreset();
    mdl_t m4 = mreset();

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1 = mreset();
            m4 = mreset();
        end else begin
            m1 = mstep(m1, s1, a1, b1, c1, 8);
            m4 = mstep(m4, s4, a4, b4, c4, 2);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy8", {31'd0, busy1}, {31'd0, m1.busy});
        chk("done8", {31'd0, done1}, {31'd0, m1.done});
        chk("diff8", {24'd0, diff1}, {24'd0, m1.diff});
        chk("bo8",   {31'd0, bo1},   {31'd0, m1.bo});
        chk("zero8", {31'd0, z1},    {31'd0, m1.z});
        chk("busy4", {31'd0, busy4}, {31'd0, m4.busy});
        chk("done4", {31'd0, done4}, {31'd0, m4.done});
        chk("diff4", {24'd0, diff4}, {24'd0, m4.diff});
        chk("bo4",   {31'd0, bo4},   {31'd0, m4.bo});
        chk("zero4", {31'd0, z4},    {31'd0, m4.z});
    end

    task automatic drive(input int sel, input bit s, input logic [7:0] a, input logic [7:0] b, input bit c);
        if (sel == 0) begin
            s1 = s; a1 = a; b1 = b; c1 = c;
        end else begin
            s4 = s; a4 = a; b4 = b; c4 = c;
        end
    endtask

    function automatic bit cur_done(input int sel);
        return (sel == 0) ? done1 : done4;
    endfunction

    function automatic bit cur_busy(input int sel);
        return (sel == 0) ? busy1 : busy4;
    endfunction

    function automatic logic [9:0] cur_res(input int sel);
        return (sel == 0) ? {diff1, bo1, z1} : {diff4, bo4, z4};
    endfunction

    task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b, input bit c,
                          input logic [7:0] ediff, input bit ebo, input bit ez, input int en);
        int lat;
        int bcnt;
        logic [9:0] res;
        @(negedge clk);
        drive(sel, 1, a, b, c);
        @(negedge clk);
        drive(sel, 0, a, b, c);
        lat  = 1;
        bcnt = 0;
        while (lat <= 30 && !cur_done(sel)) begin
            if (cur_busy(sel)) bcnt++;
            @(negedge clk);
            lat++;
        end
        res = cur_res(sel);
        chk("latency", lat - 1, en);
        chk("busy_cycles", bcnt, en);
        chk("lit_diff", {24'd0, res[9:2]}, {24'd0, ediff});
        chk("lit_borrow", {31'd0, res[1]}, {31'd0, ebo});
        chk("lit_zero", {31'd0, res[0]}, {31'd0, ez});
    endtask

    initial begin
        int ndone;
        int t1;
        int t2;
        logic [7:0] d_first;
        logic [7:0] d_second;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_op(0, 8'h05, 8'h03, 0, 8'h02, 0, 0, 8);
        run_op(0, 8'h03, 8'h05, 0, 8'hFE, 1, 0, 8);
        run_op(0, 8'h00, 8'h00, 1, 8'hFF, 1, 0, 8);
        run_op(0, 8'h5A, 8'h5A, 0, 8'h00, 0, 1, 8);

        // Start pulsed during RUN must not be queued.
        @(negedge clk);
        drive(0, 1, 8'h80, 8'h01, 0);
        @(negedge clk);
        drive(0, 0, 8'h80, 8'h01, 0);
        repeat (2) @(negedge clk);
        drive(0, 1, 8'h00, 8'hFF, 0);
        @(negedge clk);
        drive(0, 0, 8'h00, 8'hFF, 0);
        ndone   = 0;
        d_first = '0;
        for (int k = 0; k < 20; k++) begin
            if (done1) begin
                ndone++;
                d_first = diff1;
                chk("ign_borrow", {31'd0, bo1}, 32'd0);
            end
            @(negedge clk);
        end
        chk("ign_done_count", ndone, 1);
        chk("ign_diff", {24'd0, d_first}, 32'h7F);

        // Start held high: back-to-back operations, second one captures updated a.
        drive(0, 1, 8'h20, 8'h03, 0);
        t1 = -1;
        t2 = -1;
        d_second = '0;
        for (int k = 0; k < 40 && t2 < 0; k++) begin
            @(negedge clk);
            if (done1) begin
                if (t1 < 0) begin
                    t1      = k;
                    d_first = diff1;
                    a1      = 8'h40;
                end else begin
                    t2       = k;
                    d_second = diff1;
                    s1       = 1'b0;
                end
            end
        end
        s1 = 1'b0;
        chk("held_interval", t2 - t1, 9);
        chk("held_diff1", {24'd0, d_first}, 32'h1D);
        chk("held_diff2", {24'd0, d_second}, 32'h3D);
        repeat (2) @(negedge clk);

        // Asynchronous reset in cycle 4 of RUN.
        drive(0, 1, 8'h33, 8'h11, 0);
        @(negedge clk);
        drive(0, 0, 8'h33, 8'h11, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_done", {31'd0, done1}, 32'd0);
        chk("rst_diff", {24'd0, diff1}, 32'd0);
        chk("rst_borrow", {31'd0, bo1}, 32'd0);
        chk("rst_zero", {31'd0, z1}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done1) ndone++;
        end
        chk("rst_no_done", ndone, 0);
        run_op(0, 8'h10, 8'h01, 0, 8'h0F, 0, 0, 8);

        run_op(1, 8'h10, 8'h01, 0, 8'h0F, 0, 0, 2);
        run_op(1, 8'h00, 8'h01, 0, 8'hFF, 1, 0, 2);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/digit_serial_subtractor.md
# digit_serial_subtractor

Multi-cycle N-bit subtractor computing diff = a − b − borrow_in by processing DIGIT bits per clock, least-significant digit first, through a single ripple-borrow digit cell. It is the parametrised sequential successor to the 1-bit full subtractor in the arithmetic library. Datapath blocks use it where a full-width combinational borrow chain is too large or too slow. Control is a start/busy/done handshake; results hold until the next operation is accepted.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 1.
- DIGIT, 1: bits processed per cycle; WIDTH must be an integer multiple of DIGIT.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled on a rising edge and accepted only in IDLE or DONE.
- a  in  WIDTH  minuend; captured on the accepting edge.
- b  in  WIDTH  subtrahend; captured on the accepting edge.
- borrow_in  in  1  initial borrow; captured on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result is valid.
- diff  out  WIDTH  difference, registered.
- borrow_out  out  1  final borrow (1 when a < b + borrow_in, unsigned).
- zero  out  1  high when diff == 0; valid with done.

## Operation
- N = WIDTH/DIGIT digit steps.
- States:
  - IDLE: no operation in progress.
  - RUN: steps counter 0..N−1.
  - DONE: lasts one cycle.
- IDLE/DONE, start=1 → RUN:
  - load A_sr←a, B_sr←b, brw←borrow_in, cnt←0.
  - diff, borrow_out and zero keep their old values until the new result lands.
- RUN, each cycle:
  - cell computes {b_o, d} = A_sr[DIGIT−1:0] − B_sr[DIGIT−1:0] − brw.
  - A_sr and B_sr shift right by DIGIT.
  - d enters R_sr from the MSB end.
  - brw←b_o, cnt←cnt+1.
- RUN, cnt == N−1:
  - perform the final step.
  - on the same edge, load diff←final R_sr, borrow_out←final b_o, zero←(final R_sr == 0).
  - go to DONE.
- DONE: done=1 for exactly one cycle. Next state is RUN if start=1, else IDLE.
- start in RUN is ignored (not queued). a, b and borrow_in changes during RUN have no effect.
- Arithmetic is unsigned modulo 2^WIDTH. The wrap-around case (a < b) produces the two's-complement pattern with borrow_out=1.
- Reset, asynchronous, at any time including mid-RUN:
  - state←IDLE, cnt←0, shift registers←0.
  - busy=0, done=0, diff=0, borrow_out=0, zero=0.
  - the in-flight operation is discarded. After rst falls, the first start is accepted normally.

## Timing
- Accepting edge E0: busy=1 from E0 through the edge that completes the last step, E0+N.
- At E0+N:
  - busy falls and done rises.
  - diff, borrow_out and zero update.
- done falls at E0+N+1 unless a new operation is accepted there; even then it falls, and busy rises.
- Latency: start edge to done = N cycles.
- Throughput with start held high: one result every N+1 cycles.
- N=1 (DIGIT=WIDTH): RUN lasts one cycle; done follows one edge after acceptance.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package arith_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - a counter width helper, $clog2 of N with a minimum of 1.
- Sub-module digit_sub: combinational DIGIT-bit ripple-borrow cell.
  - inputs: a_d[DIGIT], b_d[DIGIT], b_i.
  - outputs: d[DIGIT], b_o.
  - built from a chain of 1-bit full-subtractor equations.
- The top level holds the FSM, counter, shift registers and output registers.

## Test plan
- WIDTH=8, DIGIT=1: a=0x05, b=0x03, borrow_in=0 → diff=0x02, borrow_out=0, zero=0; done exactly 8 cycles after the start edge; busy high for 8 cycles.
- WIDTH=8, DIGIT=1, wrap-around: a=0x03, b=0x05, borrow_in=0 → diff=0xFE, borrow_out=1. Also a=0x00, b=0x00, borrow_in=1 → diff=0xFF, borrow_out=1.
- Zero flag: a=0x5A, b=0x5A, borrow_in=0 → diff=0x00, zero=1, borrow_out=0.
- Ignored start:
  - issue a=0x80, b=0x01.
  - pulse start with a=0x00, b=0xFF at cycle 3 of RUN.
  - expect one done only, with diff=0x7F, borrow_out=0.
  - with start held high, a second operation begins on the done edge and completes after N+1 cycles.
- Reset mid-operation: assert rst asynchronously at cycle 4 of RUN → all outputs 0 immediately, no done. Then a=0x10, b=0x01 → diff=0x0F after 8 cycles.
- WIDTH=8, DIGIT=4: a=0x10, b=0x01 → diff=0x0F, borrow_out=0, done 2 cycles after start. Then a=0x00, b=0x01 → diff=0xFF, borrow_out=1.
